nv_nvdla_sdp_hls_sync_alu: RTL and testbench



---
 rtl/nv_nvdla_sdp_hls_sync_alu.sv | 126 ++++++++++++
 tb/tb_nv_nvdla_sdp_hls_sync_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_sdp_hls_sync_alu.sv
// nv_nvdla_sdp_hls_sync_alu
//   Two-stage pipelined ALU on the joined operand pair from the SDP sync stage.
//   Stage 1 sign-extends A to OUT_WIDTH. It also shifts B left and saturates it.
//   Stage 2 forms MAX, MIN, saturating SUM, EQL, or bypass A.
//   Both stages use valid/ready handshakes and pass backpressure through.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, async active-high reset
//   chn_in_pvld / chn_in_prdy       : operand pair handshake
//   alu_data_a / alu_data_b         : signed operands (DATA_WIDTH)
//   cfg_alu_bypass/algo/shift       : per-beat config, sampled with the operands
//   chn_out_pvld / chn_out_prdy     : result handshake
//   alu_data_out                    : signed result (DATA_WIDTH+1)
module nv_nvdla_sdp_hls_sync_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  chn_in_pvld,
    output logic                  chn_in_prdy,
    input  logic [DATA_WIDTH-1:0] alu_data_a,
    input  logic [DATA_WIDTH-1:0] alu_data_b,
    input  logic                  cfg_alu_bypass,
    input  logic [1:0]            cfg_alu_algo,
    input  logic [2:0]            cfg_alu_shift,
    output logic                  chn_out_pvld,
    input  logic                  chn_out_prdy,
    output logic [DATA_WIDTH:0]   alu_data_out
);

    localparam int OW = DATA_WIDTH + 1;
    localparam int BW = DATA_WIDTH + 8;

    localparam logic [OW-1:0] SatPos = {1'b0, {DATA_WIDTH{1'b1}}};
    localparam logic [OW-1:0] SatNeg = {1'b1, {DATA_WIDTH{1'b0}}};

    // Pipe state
    logic                 v1;
    logic                 v2;
    logic signed [OW-1:0] a1;
    logic signed [OW-1:0] b1;
    logic                 bypass1;
    logic [1:0]           algo1;
    logic [OW-1:0]        out_data;

    logic s2_accept;
    logic s1_accept;
    logic in_xfer;

    assign s2_accept    = !v2 || chn_out_prdy;
    assign s1_accept    = !v1 || s2_accept;
    assign chn_in_prdy  = !nvdla_core_rst && s1_accept;
    assign in_xfer      = chn_in_pvld && chn_in_prdy;
    assign chn_out_pvld = v2;
    assign alu_data_out = out_data;

    // Stage 1: operand conditioning
    logic [BW-1:0] b_shift;
    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_sat;

    always_comb begin
        a_ext   = {alu_data_a[DATA_WIDTH-1], alu_data_a};
        b_shift = {{8{alu_data_b[DATA_WIDTH-1]}}, alu_data_b} << cfg_alu_shift;
        // B fits in OUT_WIDTH only when all bits above the result sign bit match it
        if (&b_shift[BW-1:OW-1] || ~|b_shift[BW-1:OW-1]) begin
            b_sat = b_shift[OW-1:0];
        end else begin
            b_sat = b_shift[BW-1] ? SatNeg : SatPos;
        end
    end

    // Stage 2: combine
    logic [OW:0]   sum_full;
    logic [OW-1:0] sum_sat;
    logic [OW-1:0] result;

    always_comb begin
        sum_full = {a1[OW-1], a1} + {b1[OW-1], b1};
        // One extra bit of headroom: overflow shows as the top two bits disagreeing
        if (sum_full[OW] != sum_full[OW-1]) begin
            sum_sat = sum_full[OW] ? SatNeg : SatPos;
        end else begin
            sum_sat = sum_full[OW-1:0];
        end

        result = a1;
        if (!bypass1) begin
            unique case (algo1)
                2'd0:    result = (a1 > b1) ? a1 : b1;
                2'd1:    result = (a1 < b1) ? a1 : b1;
                2'd2:    result = sum_sat;
                default: result = {{DATA_WIDTH{1'b0}}, (a1 == b1)};
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            a1       <= '0;
            b1       <= '0;
            bypass1  <= 1'b0;
            algo1    <= 2'd0;
            out_data <= '0;
        end else begin
            if (s1_accept) begin
                v1 <= chn_in_pvld;
            end
            if (in_xfer) begin
                a1      <= a_ext;
                b1      <= b_sat;
                bypass1 <= cfg_alu_bypass;
                algo1   <= cfg_alu_algo;
            end
            if (s2_accept) begin
                v2 <= v1;
            end
            // Load only on a real beat so the output stays put between beats
            if (s2_accept && v1) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_sync_alu.sv
// Bench for nv_nvdla_sdp_hls_sync_alu: directed corner beats plus randomized traffic,
// checked against an arithmetic reference model and an occupancy-based handshake model.
module tb_nv_nvdla_sdp_hls_sync_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_pvld = 1'b0;
    logic        in_prdy;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        bypass = 1'b0;
    logic [1:0]  algo = 2'd0;
    logic [2:0]  shift = 3'd0;
    logic        out_pvld;
    logic        out_prdy = 1'b0;
    logic [32:0] data_out;

    nv_nvdla_sdp_hls_sync_alu #(.DATA_WIDTH(32)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .chn_in_pvld    (in_pvld),
        .chn_in_prdy    (in_prdy),
        .alu_data_a     (data_a),
        .alu_data_b     (data_b),
        .cfg_alu_bypass (bypass),
        .cfg_alu_algo   (algo),
        .cfg_alu_shift  (shift),
        .chn_out_pvld   (out_pvld),
        .chn_out_prdy   (out_prdy),
        .alu_data_out   (data_out)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    bit          pushed_last = 0;
    bit          accepted = 0;
    bit          prev_stall = 0;
    logic [32:0] prev_data = '0;
    bit          rand_prdy = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: signed arithmetic on wide integers, clamped to the 33-bit signed range
    function automatic logic [32:0] model(logic [31:0] a, logic [31:0] b, logic byp,
                                          logic [1:0] alg, logic [2:0] sh);
        longint lo = -(longint'(1) << 32);
        longint hi = (longint'(1) << 32) - 1;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b)) * (longint'(1) << sh);
        longint r;
        if (sb > hi) sb = hi;
        if (sb < lo) sb = lo;
        if (byp) r = sa;
        else begin
            case (alg)
                2'd0: r = (sa > sb) ? sa : sb;
                2'd1: r = (sa < sb) ? sa : sb;
                2'd2: begin
                    r = sa + sb;
                    if (r > hi) r = hi;
                    if (r < lo) r = lo;
                end
                default: r = (sa == sb) ? 1 : 0;
            endcase
        end
        return r[32:0];
    endfunction

    // One clock: check at the negedge, then advance past the next rising edge
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        check("in_prdy", 64'(in_prdy), 64'(!(exp_q.size() == 2 && !out_prdy)));
        check("out_pvld", 64'(out_pvld),
              64'(exp_q.size() >= 2 || (exp_q.size() == 1 && !pushed_last)));
        if (prev_stall) begin
            check("hold_pvld", 64'(out_pvld), 64'(1));
            check("hold_data", 64'(data_out), 64'(prev_data));
        end
        prev_stall = out_pvld && !out_prdy;
        prev_data  = data_out;
        if (out_pvld && out_prdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data", 64'(data_out), 64'(e));
        end
        pushed_last = 0;
        accepted    = 0;
        if (in_pvld && in_prdy) begin
            exp_q.push_back(model(data_a, data_b, bypass, algo, shift));
            pushed_last = 1;
            accepted    = 1;
        end
        @(posedge clk);
        #1;
        if (rand_prdy) out_prdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic byp,
                        input logic [1:0] alg, input logic [2:0] sh);
        data_a  = a;
        data_b  = b;
        bypass  = byp;
        algo    = alg;
        shift   = sh;
        in_pvld = 1'b1;
        accepted = 0;
        for (int k = 0; k < 200 && !accepted; k++) tick();
        if (!accepted) check("send_timeout", 64'(0), 64'(1));
        in_pvld = 1'b0;
    endtask

    task automatic idle(input int n);
        in_pvld = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        check("rst_out_pvld", 64'(out_pvld), 64'(0));
        check("rst_in_prdy", 64'(in_prdy), 64'(0));
        check("rst_data", 64'(data_out), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_prdy = 1'b1;

        // Saturation corners
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 2'd2, 3'd0);
        idle(3);
        send(32'h7FFF_FFFF, 32'h4000_0001, 1'b0, 2'd2, 3'd1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 2'd2, 3'd7);
        idle(3);

        // Back-to-back mixed ops
        send(-32'sd5, 32'd3, 1'b0, 2'd0, 3'd0);
        send(-32'sd5, 32'd3, 1'b0, 2'd1, 3'd0);
        send(-32'sd5, 32'd3, 1'b0, 2'd3, 3'd0);
        send(-32'sd5, 32'd3, 1'b1, 2'd2, 3'd0);
        send(32'd6, 32'd3, 1'b0, 2'd3, 3'd1);
        idle(3);

        // Incrementing SUM stream under random backpressure
        rand_prdy = 1;
        for (int i = 0; i < 16; i++) send(32'(i), 32'd0, 1'b0, 2'd2, 3'd0);
        out_prdy = 1'b1;
        rand_prdy = 0;
        idle(4);

        // Full pipe, then simultaneous push and pop
        out_prdy = 1'b0;
        send(32'd100, 32'd1, 1'b0, 2'd2, 3'd0);
        send(32'd200, 32'd2, 1'b0, 2'd2, 3'd0);
        idle(2);
        out_prdy = 1'b1;
        send(32'd300, 32'd3, 1'b0, 2'd2, 3'd0);
        send(32'd400, 32'd4, 1'b0, 2'd2, 3'd0);
        idle(4);

        // Randomized traffic
        rand_prdy = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(pick(), pick(), 1'($urandom_range(0, 1) & $urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
        out_prdy = 1'b1;
        rand_prdy = 0;
        idle(4);

        // Reset with two beats in flight
        out_prdy = 1'b0;
        send(32'd11, 32'd1, 1'b0, 2'd2, 3'd0);
        send(32'd22, 32'd2, 1'b0, 2'd2, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_pvld", 64'(out_pvld), 64'(0));
        check("midrst_in_prdy", 64'(in_prdy), 64'(0));
        check("midrst_data", 64'(data_out), 64'(0));
        exp_q.delete();
        pushed_last = 0;
        prev_stall  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_prdy = 1'b1;
        idle(1);
        send(32'hFFFF_FFF0, 32'd7, 1'b0, 2'd0, 3'd2);
        idle(3);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
